dds_sweep_ctrl: RTL



---
 rtl/dds_sweep_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dds_sweep_ctrl
// Description : Frequency/phase word sequencer for the DDS generator. It
//               supports tone, single sweep, sawtooth and triangle modes.
//               The optional macro DDS_SWEEP_TRI_EN enables triangle mode 3.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [31:0]        cfg_k_start,
    input  logic [31:0]        cfg_k_stop,
    input  logic [31:0]        cfg_k_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic [10:0]        cfg_p,
    input  logic               start,
    input  logic               abort,
    output logic [31:0]        K,
    output logic [10:0]        P,
    output logic               busy,
    output logic               sweep_done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [DWELL_W-1:0] c_dwell_one = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [31:0]          r_sh_start;
    logic [31:0]          r_sh_stop;
    logic [31:0]          r_sh_step;
    logic [DWELL_W-1:0]   r_sh_dwell;
    logic [1:0]           r_sh_mode;
    logic [10:0]          r_sh_p;
    logic [31:0]          r_org;
    logic [31:0]          r_tgt;
    logic                 r_up;
    logic [DWELL_W-1:0]   r_cnt;
    logic [31:0]          r_k;
    logic [10:0]          r_p;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ready;

    logic [31:0]          w_ld_start;
    logic [31:0]          w_ld_stop;
    logic [DWELL_W-1:0]   w_ld_dwell;
    logic [10:0]          w_ld_p;
    logic [31:0]          w_step;
    logic [31:0]          w_fwd;

    // Move k by step toward target; a 33-bit result catches wrap and overshoot.
    function automatic logic [31:0] step_toward(
        input logic [31:0] k,
        input logic [31:0] step,
        input logic [31:0] target,
        input logic        up
    );
        logic [32:0] s;
        logic [31:0] res;
        if (up) begin
            s   = {1'b0, k} + {1'b0, step};
            res = (s[32] || (s[31:0] > target)) ? target : s[31:0];
        end else begin
            s   = {1'b0, k} - {1'b0, step};
            res = (s[32] || (s[31:0] < target)) ? target : s[31:0];
        end
        return res;
    endfunction

    // A config offered in the same cycle as start takes effect immediately.
    assign w_ld_start = cfg_valid ? cfg_k_start : r_sh_start;
    assign w_ld_stop  = cfg_valid ? cfg_k_stop  : r_sh_stop;
    assign w_ld_dwell = cfg_valid ? cfg_dwell   : r_sh_dwell;
    assign w_ld_p     = cfg_valid ? cfg_p       : r_sh_p;

    assign w_step = (r_sh_step == 32'd0) ? 32'd1 : r_sh_step;
    assign w_fwd  = step_toward(r_k, w_step, r_tgt, r_up);

`ifdef DDS_SWEEP_TRI_EN
    logic [31:0] w_rev;
    assign w_rev = step_toward(r_k, w_step, r_org, ~r_up);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sh_start <= 32'd0;
            r_sh_stop  <= 32'd0;
            r_sh_step  <= 32'd0;
            r_sh_dwell <= '0;
            r_sh_mode  <= 2'd0;
            r_sh_p     <= 11'd0;
            r_org      <= 32'd0;
            r_tgt      <= 32'd0;
            r_up       <= 1'b1;
            r_cnt      <= '0;
            r_k        <= 32'd0;
            r_p        <= 11'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_sh_start <= cfg_k_start;
                        r_sh_stop  <= cfg_k_stop;
                        r_sh_step  <= cfg_k_step;
                        r_sh_dwell <= cfg_dwell;
                        r_sh_mode  <= cfg_mode;
                        r_sh_p     <= cfg_p;
                    end
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_k     <= w_ld_start;
                        r_p     <= w_ld_p;
                        r_cnt   <= w_ld_dwell;
                        r_org   <= w_ld_start;
                        r_tgt   <= w_ld_stop;
                        r_up    <= (w_ld_start <= w_ld_stop);
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_k     <= 32'd0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_dwell_one;
                    end else begin
                        r_cnt <= r_sh_dwell;
                        if (r_sh_mode != 2'd0) begin
                            if (r_k != r_tgt) begin
                                r_k <= w_fwd;
                            end else if (r_sh_mode == 2'd1) begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_ready <= 1'b1;
                                r_done  <= 1'b1;
`ifdef DDS_SWEEP_TRI_EN
                            end else if (r_sh_mode == 2'd3) begin
                                r_org <= r_tgt;
                                r_tgt <= r_org;
                                r_up  <= ~r_up;
                                r_k   <= w_rev;
`endif
                            end else begin
                                r_k <= r_org;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign K          = r_k;
    assign P          = r_p;
    assign busy       = r_busy;
    assign sweep_done = r_done;
    assign cfg_ready  = r_ready;

endmodule
`default_nettype wire
